dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_ctrl_pkg.sv | 17 +
 rtl/dmem_wdt.sv | 32 +++
 rtl/dmem_ctrl.sv | 103 ++++++++++
 tb/tb_dmem_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, default
// watchdog limit and the legacy chip-enable / write-disable levels.
package dmem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int unsigned DEF_TIMEOUT   = 255;
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;

endpackage

// File: rtl/dmem_wdt.sv
// Per-phase watchdog: counts enabled cycles, clears on request, and flags
// expiry combinationally when the count reaches TIMEOUT.
module dmem_wdt
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int unsigned   CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = en && (count == LIMIT);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the mem stage and a req/gnt/rvalid SRAM.
// Every access reads first; stores then write back the merged word.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ram_ce_i,
  input  logic                  ram_w_request_i,
  input  logic [ADDR_WIDTH-1:0] ram_addr_i,
  input  logic [DATA_WIDTH-1:0] ram_data_i,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  stall_req_o,
  output logic                  bus_err_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-3:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic                  sram_gnt_i,
  input  logic                  sram_rvalid_i,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  state_t                state;
  state_t                next;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wdt_en;
  logic                  wdt_clr;
  logic                  expire;
  logic                  unused_addr_bits;

  dmem_wdt #(
    .TIMEOUT(TIMEOUT)
  ) u_wdt (
    .clk   (clk_i),
    .rst   (rst_i),
    .clr   (wdt_clr),
    .en    (wdt_en),
    .expire(expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  // Watchdog expiry outranks any handshake arriving in the same cycle.
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    if (ram_ce_i == CHIP_ENABLE) next = RD_REQ;
      RD_REQ:  if (expire) next = DONE;
               else if (sram_gnt_i) next = RD_WAIT;
      RD_WAIT: if (expire) next = DONE;
               else if (sram_rvalid_i) next = ram_w_request_i ? WR_REQ : DONE;
      WR_REQ:  if (expire || sram_gnt_i) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    sram_req_o = 1'b0;
    sram_we_o  = WRITE_DISABLE;
    unique case (state)
      RD_REQ: sram_req_o = 1'b1;
      WR_REQ: begin
        sram_req_o = 1'b1;
        sram_we_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (expire) begin
      rdata_q <= '0;
    end else if ((state == RD_WAIT) && sram_rvalid_i) begin
      rdata_q <= sram_rdata_i;
    end
  end

  assign wdt_en  = (state == RD_REQ) || (state == RD_WAIT) || (state == WR_REQ);
  assign wdt_clr = (next != state);

  assign stall_req_o  = ram_ce_i && (state != DONE) && !rst_i;
  assign bus_err_o    = expire;
  assign ram_data_o   = rdata_q;
  assign sram_addr_o  = ram_addr_i[ADDR_WIDTH-1:2];
  assign sram_wdata_o = ram_data_i;

  assign unused_addr_bits = ^ram_addr_i[1:0];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural SRAM (programmable gnt and
// rvalid latency) and scoreboard queues for read data, read and write traffic.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        wreq = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata_in = '0;
  logic [31:0] ram_data;
  logic        stall;
  logic        bus_err;
  logic        sram_req;
  logic        sram_we;
  logic [29:0] sram_addr;
  logic [31:0] sram_wdata;
  logic        sram_gnt;
  logic        sram_rvalid;
  logic [31:0] sram_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd_q[$];
  logic [29:0] ra_q[$];
  logic [61:0] wr_q[$];

  int unsigned gnt_delay = 0;
  int unsigned rv_delay  = 1;
  bit          gnt_never = 1'b0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (255)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .ram_ce_i       (ce),
    .ram_w_request_i(wreq),
    .ram_addr_i     (addr),
    .ram_data_i     (wdata_in),
    .ram_data_o     (ram_data),
    .stall_req_o    (stall),
    .bus_err_o      (bus_err),
    .sram_req_o     (sram_req),
    .sram_we_o      (sram_we),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_gnt_i     (sram_gnt),
    .sram_rvalid_i  (sram_rvalid),
    .sram_rdata_i   (sram_rdata)
  );

  // SRAM model; reset drops any pending read and restores the preload image.
  logic [31:0] mem [0:255];
  int unsigned wait_cnt;
  int unsigned rv_cnt;
  bit          rv_pend;
  logic [31:0] rv_data;

  assign sram_gnt    = sram_req && !gnt_never && (wait_cnt >= gnt_delay);
  assign sram_rvalid = rv_pend && (rv_cnt == 0);
  assign sram_rdata  = rv_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[8'h41] <= 32'hDEADBEEF;
      mem[8'h82] <= 32'h11223344;
      mem[8'hC0] <= 32'hCAFEF00D;
      mem[8'hC4] <= 32'h5A5AA5A5;
      wait_cnt   <= 0;
      rv_cnt     <= 0;
      rv_pend    <= 1'b0;
      rv_data    <= '0;
    end else begin
      wait_cnt <= (sram_req && !sram_gnt) ? wait_cnt + 1 : 0;
      if (sram_rvalid) rv_pend <= 1'b0;
      else if (rv_pend) rv_cnt <= rv_cnt - 1;
      if (sram_req && sram_gnt && !sram_we) begin
        rv_pend <= 1'b1;
        rv_cnt  <= rv_delay - 1;
        rv_data <= mem[sram_addr[7:0]];
      end
      if (sram_req && sram_gnt && sram_we) mem[sram_addr[7:0]] <= sram_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present one mem-stage access and follow it until stall drops (DONE).
  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [31:0] exp_r, input int exp_stall, input int exp_err);
    int          stall_cyc = 0;
    int          err_cyc   = 0;
    int          wr_cyc    = 0;
    bit          done      = 1'b0;
    bit          prev_req  = 1'b0;
    logic [29:0] prev_addr = '0;
    logic [29:0] last_rd   = '1;
    ce = 1'b1; wreq = w; addr = a; wdata_in = d;
    rd_q.push_back(exp_r);
    if (!gnt_never) ra_q.push_back(a[31:2]);
    if (w && exp_err == 0) wr_q.push_back({a[31:2], d});
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk);
      if (sram_req && prev_req) chk("addr_stable", sram_addr, prev_addr);
      prev_req  = sram_req;
      prev_addr = sram_addr;
      if (sram_req && sram_gnt && !sram_we) begin
        last_rd = sram_addr;
        chk("rd_addr", sram_addr, (ra_q.size() != 0) ? ra_q.pop_front() : '1);
      end
      if (sram_req && sram_gnt && sram_we) begin
        wr_cyc++;
        chk("rmw_order", last_rd, sram_addr);
        chk("wr_addr_data", {sram_addr, sram_wdata}, (wr_q.size() != 0) ? wr_q.pop_front() : '1);
      end
      if (bus_err) err_cyc++;
      if (stall) stall_cyc++;
      else done = 1'b1;
    end
    chk("done_reached", done, 1);
    chk("ram_data", ram_data, rd_q.pop_front());
    chk("stall_cycles", stall_cyc, exp_stall);
    chk("bus_err_pulses", err_cyc, exp_err);
    chk("write_count", wr_cyc, (w && exp_err == 0) ? 1 : 0);
    @(posedge clk); #1;
    ce = 1'b0; wreq = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; addr = 32'h104;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_req", sram_req, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_ram_data", ram_data, 0);
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b0;
    @(posedge clk); #1;

    access(32'h104, 1'b0, 32'h0, 32'hDEADBEEF, 3, 0);
    chk("load_sram_addr", sram_addr, 30'h41);
    access(32'h20A, 1'b1, 32'h11AA3344, 32'h11223344, 4, 0);

    gnt_delay = 5; rv_delay = 7;
    access(32'h310, 1'b0, 32'h0, 32'h5A5AA5A5, 14, 0);

    gnt_delay = 0; rv_delay = 1; gnt_never = 1'b1;
    access(32'h104, 1'b0, 32'h0, 32'h0, 257, 1);
    gnt_never = 1'b0;

    access(32'h104, 1'b0, 32'h0, 32'hDEADBEEF, 3, 0);
    access(32'h300, 1'b1, 32'h12345678, 32'hCAFEF00D, 4, 0);

    rv_delay = 10; ce = 1'b1; wreq = 1'b0; addr = 32'h104;
    repeat (3) @(negedge clk);
    chk("pre_rst_rd_wait", {sram_req, stall}, 2'b01);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_stall", stall, 0);
    chk("async_rst_req", sram_req, 0);
    chk("async_rst_we", sram_we, 0);
    chk("async_rst_bus_err", bus_err, 0);
    chk("async_rst_ram_data", ram_data, 0);
    @(posedge clk); #1;
    rst = 1'b0; ce = 1'b0; rv_delay = 1;
    @(posedge clk); #1;

    access(32'h208, 1'b0, 32'h0, 32'h11223344, 3, 0);
    access(32'h104, 1'b1, 32'h0BADCAFE, 32'hDEADBEEF, 4, 0);
    chk("queues_drained", rd_q.size() + ra_q.size() + wr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
